// File: rtl/xor_stream_pkg.sv
// Shared definitions for the XOR stream decoder.
//   state_t           : framing FSM states (HUNT / DATA)
//   SYNC_WORD_DEFAULT : default decoded-bit pattern that opens a frame
//   FRAME_LEN_DEFAULT : default number of payload bytes per frame
package xor_stream_pkg;

  typedef enum logic {
    HUNT = 1'b0,
    DATA = 1'b1
  } state_t;

  localparam logic [7:0] SYNC_WORD_DEFAULT = 8'hA5;
  localparam int unsigned FRAME_LEN_DEFAULT = 4;

endpackage

// File: rtl/xor_stream_decoder_byte_fifo2.sv
// Two-entry byte FIFO sitting between the frame assembler and the consumer.
//   clk, rst   : clock, asynchronous active-high reset
//   push       : write data this cycle (ignored when full)
//   data       : byte to write
//   pop_req    : consumer ready; a pop happens only when the FIFO is non-empty
//   head       : oldest entry, 8'h00 while empty
//   valid      : FIFO not empty
//   full       : FIFO holds two entries
module byte_fifo2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] data,
  input  logic       pop_req,
  output logic [7:0] head,
  output logic       valid,
  output logic       full
);

  logic [7:0] mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic       do_push;
  logic       do_pop;

  assign valid   = (count != 2'd0);
  assign full    = (count == 2'd2);
  assign do_pop  = pop_req && valid;
  // A push into a full FIFO cannot happen because the producer is throttled
  // by full; the guard only keeps the storage consistent regardless.
  assign do_push = push && !full;
  assign head    = valid ? mem[rd_ptr] : 8'h00;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= 8'h00;
      mem[1] <= 8'h00;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/xor_stream_decoder.sv
// XOR stream decoder: descrambles a keyed serial bit stream, hunts for a
// sync word and assembles the following FRAME_LEN payload bytes (MSB first)
// into a 2-entry output FIFO.
//   clk, rst  : clock, asynchronous active-high reset
//   in_bit    : encoded serial bit
//   in_key    : key bit sampled together with in_bit
//   in_valid  : in_bit/in_key valid
//   in_ready  : a bit is accepted this cycle (low only when the FIFO is full)
//   out_byte  : head-of-FIFO decoded byte (8'h00 while empty)
//   out_valid : FIFO not empty
//   out_ready : consumer takes out_byte
//   in_frame  : FSM is in DATA
module xor_stream_decoder
  import xor_stream_pkg::*;
#(
  parameter logic [7:0]  SYNC_WORD = SYNC_WORD_DEFAULT,
  parameter int unsigned FRAME_LEN = FRAME_LEN_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_bit,
  input  logic       in_key,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_byte,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       in_frame
);

  localparam logic [7:0] LAST_BYTE = 8'(FRAME_LEN - 1);

  state_t     state_q;
  state_t     state_d;
  logic [7:0] window_q;
  logic       prev_q;
  logic [2:0] bit_cnt_q;
  logic [7:0] byte_cnt_q;
  logic [6:0] data_sr_q;

  logic       fifo_full;
  logic       accept;
  logic       d;
  logic [7:0] window_upd;
  logic [7:0] byte_asm;
  logic       push;

  assign in_ready   = !fifo_full;
  assign accept     = in_valid && in_ready;
  assign d          = in_bit ^ prev_q ^ ~in_key;
  assign window_upd = {window_q[6:0], d};
  assign byte_asm   = {data_sr_q, d};
  assign in_frame   = (state_q == DATA);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= HUNT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    case (state_q)
      HUNT: begin
        if (accept && (window_upd == SYNC_WORD)) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (accept && (bit_cnt_q == 3'd7)) begin
          push = 1'b1;
          if (byte_cnt_q == LAST_BYTE) begin
            state_d = HUNT;
          end
        end
      end
      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      window_q   <= 8'h00;
      prev_q     <= 1'b0;
      bit_cnt_q  <= 3'd0;
      byte_cnt_q <= 8'd0;
      data_sr_q  <= 7'd0;
    end else if (accept) begin
      prev_q <= in_bit;
      if (state_q == HUNT) begin
        window_q <= window_upd;
        if (state_d == DATA) begin
          bit_cnt_q  <= 3'd0;
          byte_cnt_q <= 8'd0;
        end
      end else begin
        data_sr_q <= byte_asm[6:0];
        bit_cnt_q <= bit_cnt_q + 3'd1;
        if (push) begin
          byte_cnt_q <= byte_cnt_q + 8'd1;
          // Frame complete: restart hunting from a clean window and
          // a zero differential reference.
          if (state_d == HUNT) begin
            window_q   <= 8'h00;
            prev_q     <= 1'b0;
            byte_cnt_q <= 8'd0;
          end
        end
      end
    end
  end

  byte_fifo2 u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .data    (byte_asm),
    .pop_req (out_ready),
    .head    (out_byte),
    .valid   (out_valid),
    .full    (fifo_full)
  );

endmodule

// File: tb/tb_xor_stream_decoder.sv
module tb_xor_stream_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_bit;
  logic       in_key;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_byte;
  logic       out_valid;
  logic       out_ready;
  logic       in_frame;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] exp_q [$];
  logic [7:0] mon_exp;
  logic       enc_prev;
  logic       key_phase;
  int         bits_sent = 0;

  always #5 clk = ~clk;

  xor_stream_decoder dut (
    .clk       (clk),
    .rst       (rst),
    .in_bit    (in_bit),
    .in_key    (in_key),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_byte  (out_byte),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .in_frame  (in_frame)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every byte the consumer takes is compared with the
  // oldest expected byte.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got %0h expected none", out_byte);
        end else begin
          mon_exp = exp_q.pop_front();
          check("scoreboard_byte", int'(out_byte), int'(mon_exp));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_raw(input logic b, input logic k);
    int guard;
    in_bit   = b;
    in_key   = k;
    in_valid = 1'b1;
    guard    = 0;
    while (!in_ready && guard < 2000) begin
      tick();
      guard++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
    end else begin
      tick();
      bits_sent++;
    end
    in_valid = 1'b0;
  endtask

  task automatic send_d(input logic dbit, input logic toggle);
    logic k;
    logic b;
    k = toggle ? key_phase : 1'b1;
    b = dbit ^ enc_prev ^ ~k;
    send_raw(b, k);
    enc_prev = b;
    if (toggle) key_phase = ~key_phase;
  endtask

  task automatic send_byte(input logic [7:0] v, input logic toggle,
                           input logic expect_it, input logic pop_last);
    if (expect_it) exp_q.push_back(v);
    for (int i = 7; i >= 0; i--) begin
      if (i == 0 && pop_last) out_ready = 1'b1;
      send_d(v[i], toggle);
    end
  endtask

  task automatic send_sync(input logic toggle);
    enc_prev  = 1'b0;
    key_phase = 1'b1;
    send_byte(8'hA5, toggle, 1'b0, 1'b0);
  endtask

  task automatic drain(input string name);
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 50) begin
      tick();
      guard++;
    end
    tick();
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    int base;
    logic seen_frame;
    logic seen_valid;

    rst       = 1'b1;
    in_bit    = 1'b0;
    in_key    = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    enc_prev  = 1'b0;
    key_phase = 1'b1;
    #1;
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_out_byte", int'(out_byte), 8'h00);
    check("reset_in_ready", int'(in_ready), 1);
    check("reset_in_frame", int'(in_frame), 0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Scenario 1: plain frame, consumer always ready
    send_sync(1'b0);
    check("s1_in_frame_after_sync", int'(in_frame), 1);
    send_byte(8'h12, 1'b0, 1'b1, 1'b0);
    check("s1_latency_valid", int'(out_valid), 1);
    check("s1_latency_byte", int'(out_byte), 8'h12);
    send_byte(8'h34, 1'b0, 1'b1, 1'b0);
    send_byte(8'h56, 1'b0, 1'b1, 1'b0);
    send_byte(8'h78, 1'b0, 1'b1, 1'b0);
    check("s1_frame_end", int'(in_frame), 0);
    drain("s1_drained");

    // Scenario 2: constant zero input never syncs
    seen_frame = 1'b0;
    seen_valid = 1'b0;
    for (int i = 0; i < 64; i++) begin
      send_raw(1'b0, 1'b1);
      seen_frame |= in_frame;
      seen_valid |= out_valid;
    end
    check("s2_no_frame", int'(seen_frame), 0);
    check("s2_no_valid", int'(seen_valid), 0);

    // Scenario 3: consumer stalled, backpressure after two bytes
    out_ready = 1'b0;
    send_sync(1'b0);
    base = bits_sent - 8;
    fork
      begin
        send_byte(8'h12, 1'b0, 1'b1, 1'b0);
        send_byte(8'h34, 1'b0, 1'b1, 1'b0);
        send_byte(8'h56, 1'b0, 1'b1, 1'b0);
        send_byte(8'h78, 1'b0, 1'b1, 1'b0);
      end
      begin
        int guard;
        guard = 0;
        @(negedge clk);
        while (in_ready && guard < 500) begin
          @(negedge clk);
          guard++;
        end
        check("s3_stall_point", bits_sent - base, 24);
        check("s3_stall_head", int'(out_byte), 8'h12);
        repeat (5) @(negedge clk);
        check("s3_stall_hold", int'(in_ready), 0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    check("s3_frame_end", int'(in_frame), 0);
    drain("s3_drained");

    // Scenario 4: reset in the middle of a frame
    out_ready = 1'b0;
    send_sync(1'b0);
    send_byte(8'h9C, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_d(1'b1, 1'b0);
    check("s4_pre_valid", int'(out_valid), 1);
    rst = 1'b1;
    #1;
    check("s4_rst_out_valid", int'(out_valid), 0);
    check("s4_rst_in_frame", int'(in_frame), 0);
    check("s4_rst_in_ready", int'(in_ready), 1);
    tick();
    tick();
    rst       = 1'b0;
    out_ready = 1'b1;
    tick();
    send_sync(1'b0);
    send_byte(8'hDE, 1'b0, 1'b1, 1'b0);
    send_byte(8'hAD, 1'b0, 1'b1, 1'b0);
    send_byte(8'hBE, 1'b0, 1'b1, 1'b0);
    send_byte(8'hEF, 1'b0, 1'b1, 1'b0);
    check("s4_frame_end", int'(in_frame), 0);
    drain("s4_drained");

    // Scenario 5: key toggles on every bit
    send_sync(1'b1);
    check("s5_in_frame_after_sync", int'(in_frame), 1);
    send_byte(8'hFF, 1'b1, 1'b1, 1'b0);
    send_byte(8'h00, 1'b1, 1'b1, 1'b0);
    send_byte(8'hFF, 1'b1, 1'b1, 1'b0);
    send_byte(8'h00, 1'b1, 1'b1, 1'b0);
    drain("s5_drained");

    // Scenario 6: simultaneous push and pop with one entry held
    out_ready = 1'b0;
    send_sync(1'b0);
    send_byte(8'h11, 1'b0, 1'b1, 1'b0);
    check("s6_one_entry_valid", int'(out_valid), 1);
    check("s6_one_entry_ready", int'(in_ready), 1);
    send_byte(8'h22, 1'b0, 1'b1, 1'b1);
    check("s6_count1_valid", int'(out_valid), 1);
    check("s6_count1_ready", int'(in_ready), 1);
    check("s6_order_head", int'(out_byte), 8'h22);
    send_byte(8'h33, 1'b0, 1'b1, 1'b0);
    send_byte(8'h44, 1'b0, 1'b1, 1'b0);
    check("s6_frame_end", int'(in_frame), 0);
    drain("s6_drained");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
